tone_decoder: RTL and testbench



---
 rtl/tone_decoder.sv | 165 ++++++++++++++++
 tb/tb_tone_decoder.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/tone_decoder.sv
// Recovers the half-period (in synth ticks) of a 1-bit square wave and flags lock on two matching intervals.
// Latency: registered outputs update on the clk edge that ends the edge-detect cycle (2-FF sync + delay flop ahead of it).
// No backpressure; note_valid is a one-clk pulse. Define TONE_DECODER_NOTE_CLASS_EN to decode hp into a note class.
module tone_decoder #(
    parameter int HP_W      = 7,
    parameter int TICK_LOG2 = 11
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            audio,
    output logic [HP_W-1:0] hp,
    output logic            active,
    output logic            note_valid,
    output logic [3:0]      note_idx
);
    localparam int CNT_W = HP_W + TICK_LOG2;
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [HP_W-1:0]  HP_MAX    = '1;
    localparam logic [CNT_W:0]   MEAS_BIAS = (CNT_W+1)'((1 << (TICK_LOG2 - 1)) + 1);
    localparam logic [CNT_W:0]   MEAS_LIM  = (CNT_W+1)'(HP_MAX);

    typedef enum logic [1:0] {SILENT, ARMED, CAND, LOCKED} state_t;

    logic             sync1_q, sync2_q, dly_q;
    logic [CNT_W-1:0] per_cnt_q, per_cnt_d;
    state_t           state_q, state_d;
    logic [HP_W-1:0]  cand_q, cand_d;
    logic [HP_W-1:0]  hp_q, hp_d;
    logic             active_q, active_d;
    logic             note_valid_q, note_valid_d;
    logic             edge_det;
    logic [CNT_W:0]   meas_sum, meas_shift;
    logic [HP_W-1:0]  meas;

`ifdef TONE_DECODER_NOTE_CLASS_EN
    logic [3:0] note_idx_q, note_idx_d;

    function automatic logic [3:0] note_class(input logic [HP_W-1:0] h);
        case (h)
            HP_W'(100): return 4'd0;
            HP_W'(84):  return 4'd1;
            HP_W'(74):  return 4'd2;
            HP_W'(70):  return 4'd3;
            HP_W'(62):  return 4'd4;
            HP_W'(55):  return 4'd5;
            HP_W'(47):  return 4'd6;
            HP_W'(42):  return 4'd7;
            HP_W'(37):  return 4'd8;
            HP_W'(35):  return 4'd9;
            HP_W'(31):  return 4'd10;
            HP_W'(28):  return 4'd11;
            default:    return 4'hF;
        endcase
    endfunction
`endif

    // per_cnt is one short of the edge-to-edge distance, hence the +1 inside MEAS_BIAS
    always_comb begin
        edge_det   = sync2_q ^ dly_q;
        meas_sum   = {1'b0, per_cnt_q} + MEAS_BIAS;
        meas_shift = meas_sum >> TICK_LOG2;
        meas       = (meas_shift > MEAS_LIM) ? HP_MAX : meas_shift[HP_W-1:0];
    end

    always_comb begin
        state_d      = state_q;
        cand_d       = cand_q;
        hp_d         = hp_q;
        active_d     = active_q;
        note_valid_d = 1'b0;
`ifdef TONE_DECODER_NOTE_CLASS_EN
        note_idx_d   = note_idx_q;
`endif
        if (edge_det)
            per_cnt_d = '0;
        else if (per_cnt_q == CNT_MAX)
            per_cnt_d = per_cnt_q;
        else
            per_cnt_d = per_cnt_q + 1'b1;

        if (edge_det) begin
            unique case (state_q)
                SILENT: state_d = ARMED;
                ARMED: begin
                    if (meas != '0) begin
                        cand_d  = meas;
                        state_d = CAND;
                    end
                end
                CAND: begin
                    if (meas == '0) begin
                        state_d = ARMED;
                    end else if (meas == cand_q) begin
                        state_d      = LOCKED;
                        hp_d         = cand_q;
                        active_d     = 1'b1;
                        note_valid_d = 1'b1;
`ifdef TONE_DECODER_NOTE_CLASS_EN
                        note_idx_d   = note_class(cand_q);
`endif
                    end else begin
                        cand_d = meas;
                    end
                end
                LOCKED: begin
                    if (meas == '0) begin
                        state_d = ARMED;
                    end else if (meas != hp_q) begin
                        cand_d  = meas;
                        state_d = CAND;
                    end
                end
                default: state_d = SILENT;
            endcase
        end else if (state_q != SILENT && per_cnt_q == CNT_MAX) begin
            // Tone lost: drop lock without announcing anything
            state_d    = SILENT;
            active_d   = 1'b0;
            hp_d       = '0;
`ifdef TONE_DECODER_NOTE_CLASS_EN
            note_idx_d = 4'hF;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            dly_q        <= 1'b0;
            per_cnt_q    <= '0;
            state_q      <= SILENT;
            cand_q       <= '0;
            hp_q         <= '0;
            active_q     <= 1'b0;
            note_valid_q <= 1'b0;
`ifdef TONE_DECODER_NOTE_CLASS_EN
            note_idx_q   <= 4'hF;
`endif
        end else begin
            sync1_q      <= audio;
            sync2_q      <= sync1_q;
            dly_q        <= sync2_q;
            per_cnt_q    <= per_cnt_d;
            state_q      <= state_d;
            cand_q       <= cand_d;
            hp_q         <= hp_d;
            active_q     <= active_d;
            note_valid_q <= note_valid_d;
`ifdef TONE_DECODER_NOTE_CLASS_EN
            note_idx_q   <= note_idx_d;
`endif
        end
    end

    assign hp         = hp_q;
    assign active     = active_q;
    assign note_valid = note_valid_q;
`ifdef TONE_DECODER_NOTE_CLASS_EN
    assign note_idx   = note_idx_q;
`else
    assign note_idx   = 4'hF;
`endif

endmodule

// File: tb/tb_tone_decoder.sv
// Directed bench for tone_decoder, run with TICK_LOG2=4 (1 tick = 16 clk, CNT_MAX = 2047) to keep runs short.
module tb_tone_decoder;
    localparam int HP_W      = 7;
    localparam int TICK_LOG2 = 4;
    // Half-periods in clk: 47 ticks = 752, 37 ticks = 592
    localparam int T47 = 752;
    localparam int T37 = 592;
`ifdef TONE_DECODER_NOTE_CLASS_EN
    localparam logic [3:0] IDX47 = 4'd6;
    localparam logic [3:0] IDX37 = 4'd8;
`else
    localparam logic [3:0] IDX47 = 4'hF;
    localparam logic [3:0] IDX37 = 4'hF;
`endif

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            audio = 1'b0;
    logic [HP_W-1:0] hp;
    logic            active;
    logic            note_valid;
    logic [3:0]      note_idx;

    int checks = 0;
    int fails = 0;
    int pulse_cnt = 0;
    int p0;

    tone_decoder #(.HP_W(HP_W), .TICK_LOG2(TICK_LOG2)) dut (
        .clk(clk), .rst_n(rst_n), .audio(audio),
        .hp(hp), .active(active), .note_valid(note_valid), .note_idx(note_idx)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (note_valid === 1'b1) pulse_cnt++;

    // Interval between consecutive toggles equals n when called back to back
    task automatic toggle_after(input int n);
        repeat (n) @(posedge clk);
        #1 audio = ~audio;
    endtask

    // 4 clk after a toggle: the edge has been processed and any pulse counted
    task automatic settle();
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        audio = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (hp !== 7'd0) begin fails++; $display("FAIL reset_hp got=%0d want=0", hp); end
        checks++; if (active !== 1'b0) begin fails++; $display("FAIL reset_active got=%b want=0", active); end
        checks++; if (note_valid !== 1'b0) begin fails++; $display("FAIL reset_note_valid got=%b want=0", note_valid); end
        checks++; if (note_idx !== 4'hF) begin fails++; $display("FAIL reset_note_idx got=%h want=f", note_idx); end
        rst_n = 1'b1;
    endtask

    task automatic test_lock();
        p0 = pulse_cnt;
        toggle_after(20);
        toggle_after(T47);
        settle();
        checks++; if (pulse_cnt - p0 !== 0) begin fails++; $display("FAIL lock_early_pulse got=%0d want=0", pulse_cnt - p0); end
        toggle_after(T47 - 4);
        settle();
        checks++; if (pulse_cnt - p0 !== 1) begin fails++; $display("FAIL lock_pulse got=%0d want=1", pulse_cnt - p0); end
        checks++; if (hp !== 7'd47) begin fails++; $display("FAIL lock_hp got=%0d want=47", hp); end
        checks++; if (active !== 1'b1) begin fails++; $display("FAIL lock_active got=%b want=1", active); end
        checks++; if (note_idx !== IDX47) begin fails++; $display("FAIL lock_note_idx got=%h want=%h", note_idx, IDX47); end
        toggle_after(T47 - 4);
        for (int i = 0; i < 3; i++) toggle_after(T47);
        settle();
        checks++; if (pulse_cnt - p0 !== 1) begin fails++; $display("FAIL lock_hold_pulses got=%0d want=1", pulse_cnt - p0); end
        checks++; if (hp !== 7'd47) begin fails++; $display("FAIL lock_hold_hp got=%0d want=47", hp); end
    endtask

    task automatic test_jitter();
        p0 = pulse_cnt;
        toggle_after(T47 + 5 - 4);
        toggle_after(T47 - 5);
        toggle_after(T47 + 3);
        toggle_after(T47 - 4);
        toggle_after(T47 + 5);
        settle();
        checks++; if (pulse_cnt - p0 !== 0) begin fails++; $display("FAIL jitter_pulses got=%0d want=0", pulse_cnt - p0); end
        checks++; if (hp !== 7'd47) begin fails++; $display("FAIL jitter_hp got=%0d want=47", hp); end
        checks++; if (active !== 1'b1) begin fails++; $display("FAIL jitter_active got=%b want=1", active); end
    endtask

    task automatic test_switch();
        p0 = pulse_cnt;
        toggle_after(T37 - 4);
        settle();
        checks++; if (pulse_cnt - p0 !== 0) begin fails++; $display("FAIL switch_cand_pulse got=%0d want=0", pulse_cnt - p0); end
        checks++; if (hp !== 7'd47) begin fails++; $display("FAIL switch_cand_hp got=%0d want=47", hp); end
        checks++; if (active !== 1'b1) begin fails++; $display("FAIL switch_cand_active got=%b want=1", active); end
        toggle_after(T37 - 4);
        settle();
        checks++; if (pulse_cnt - p0 !== 1) begin fails++; $display("FAIL switch_pulse got=%0d want=1", pulse_cnt - p0); end
        checks++; if (hp !== 7'd37) begin fails++; $display("FAIL switch_hp got=%0d want=37", hp); end
        checks++; if (active !== 1'b1) begin fails++; $display("FAIL switch_active got=%b want=1", active); end
        checks++; if (note_idx !== IDX37) begin fails++; $display("FAIL switch_note_idx got=%h want=%h", note_idx, IDX37); end
    endtask

    // 760 clk rounds up to 48 ticks, 759 clk rounds down to 47
    task automatic test_rounding();
        p0 = pulse_cnt;
        toggle_after(760 - 4);
        toggle_after(760);
        settle();
        checks++; if (pulse_cnt - p0 !== 1) begin fails++; $display("FAIL round_up_pulse got=%0d want=1", pulse_cnt - p0); end
        checks++; if (hp !== 7'd48) begin fails++; $display("FAIL round_up_hp got=%0d want=48", hp); end
        checks++; if (note_idx !== 4'hF) begin fails++; $display("FAIL round_up_note_idx got=%h want=f", note_idx); end
        toggle_after(759 - 4);
        toggle_after(759);
        settle();
        checks++; if (pulse_cnt - p0 !== 2) begin fails++; $display("FAIL round_down_pulse got=%0d want=2", pulse_cnt - p0); end
        checks++; if (hp !== 7'd47) begin fails++; $display("FAIL round_down_hp got=%0d want=47", hp); end
    endtask

    // Last edge processed 3 clk after the toggle; timeout lands 2048 clk after that
    task automatic test_timeout();
        p0 = pulse_cnt;
        toggle_after(T47 - 4);
        settle();
        repeat (2046) @(posedge clk);
        #1;
        checks++; if (active !== 1'b1) begin fails++; $display("FAIL timeout_early_active got=%b want=1", active); end
        checks++; if (hp !== 7'd47) begin fails++; $display("FAIL timeout_early_hp got=%0d want=47", hp); end
        @(posedge clk);
        #1;
        checks++; if (active !== 1'b0) begin fails++; $display("FAIL timeout_active got=%b want=0", active); end
        checks++; if (hp !== 7'd0) begin fails++; $display("FAIL timeout_hp got=%0d want=0", hp); end
        checks++; if (note_idx !== 4'hF) begin fails++; $display("FAIL timeout_note_idx got=%h want=f", note_idx); end
        checks++; if (pulse_cnt - p0 !== 0) begin fails++; $display("FAIL timeout_pulse got=%0d want=0", pulse_cnt - p0); end
    endtask

    task automatic test_glitch();
        p0 = pulse_cnt;
        toggle_after(10);
        toggle_after(5);
        settle();
        checks++; if (active !== 1'b0) begin fails++; $display("FAIL glitch_active got=%b want=0", active); end
        checks++; if (hp !== 7'd0) begin fails++; $display("FAIL glitch_hp got=%0d want=0", hp); end
        checks++; if (pulse_cnt - p0 !== 0) begin fails++; $display("FAIL glitch_pulse got=%0d want=0", pulse_cnt - p0); end
        toggle_after(T47 - 4);
        settle();
        checks++; if (pulse_cnt - p0 !== 0) begin fails++; $display("FAIL glitch_cand_pulse got=%0d want=0", pulse_cnt - p0); end
        toggle_after(T47 - 4);
        settle();
        checks++; if (pulse_cnt - p0 !== 1) begin fails++; $display("FAIL glitch_relock_pulse got=%0d want=1", pulse_cnt - p0); end
        checks++; if (hp !== 7'd47) begin fails++; $display("FAIL glitch_relock_hp got=%0d want=47", hp); end
        checks++; if (active !== 1'b1) begin fails++; $display("FAIL glitch_relock_active got=%b want=1", active); end
    endtask

    // 2048-clk interval: the edge arrives exactly when per_cnt saturates
    task automatic test_saturated_edge();
        p0 = pulse_cnt;
        toggle_after(2048 - 4);
        settle();
        checks++; if (active !== 1'b1) begin fails++; $display("FAIL sat_cand_active got=%b want=1", active); end
        checks++; if (hp !== 7'd47) begin fails++; $display("FAIL sat_cand_hp got=%0d want=47", hp); end
        checks++; if (pulse_cnt - p0 !== 0) begin fails++; $display("FAIL sat_cand_pulse got=%0d want=0", pulse_cnt - p0); end
        toggle_after(2048 - 4);
        settle();
        checks++; if (pulse_cnt - p0 !== 1) begin fails++; $display("FAIL sat_lock_pulse got=%0d want=1", pulse_cnt - p0); end
        checks++; if (hp !== 7'd127) begin fails++; $display("FAIL sat_lock_hp got=%0d want=127", hp); end
        checks++; if (note_idx !== 4'hF) begin fails++; $display("FAIL sat_lock_note_idx got=%h want=f", note_idx); end
    endtask

    task automatic test_reset_mid_lock();
        @(posedge clk);
        #1 rst_n = 1'b0;
        audio = 1'b0;
        @(posedge clk);
        #1;
        checks++; if (hp !== 7'd0) begin fails++; $display("FAIL rst_lock_hp got=%0d want=0", hp); end
        checks++; if (active !== 1'b0) begin fails++; $display("FAIL rst_lock_active got=%b want=0", active); end
        checks++; if (note_valid !== 1'b0) begin fails++; $display("FAIL rst_lock_note_valid got=%b want=0", note_valid); end
        checks++; if (note_idx !== 4'hF) begin fails++; $display("FAIL rst_lock_note_idx got=%h want=f", note_idx); end
        rst_n = 1'b1;
        p0 = pulse_cnt;
        toggle_after(10);
        toggle_after(T47);
        settle();
        checks++; if (pulse_cnt - p0 !== 0) begin fails++; $display("FAIL relock_early_pulse got=%0d want=0", pulse_cnt - p0); end
        toggle_after(T47 - 4);
        settle();
        checks++; if (pulse_cnt - p0 !== 1) begin fails++; $display("FAIL relock_pulse got=%0d want=1", pulse_cnt - p0); end
        checks++; if (hp !== 7'd47) begin fails++; $display("FAIL relock_hp got=%0d want=47", hp); end
        checks++; if (active !== 1'b1) begin fails++; $display("FAIL relock_active got=%b want=1", active); end
    endtask

    initial begin
        test_reset();
        test_lock();
        test_jitter();
        test_switch();
        test_rounding();
        test_timeout();
        test_glitch();
        test_saturated_edge();
        test_reset_mid_lock();
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
